// File: rtl/lz77_token_decoder.sv
// ---------------------------------------------------------------------------
// lz77_token_decoder
//
// Rebuilds the original byte stream from the LZ77 compressor's 14-bit tokens
// {offset[2:0], length[2:0], next_char[7:0]}. A token of length L produces L
// bytes copied out of a small history window, followed by its literal
// next_char. Output is one byte per cycle on a valid/ready interface.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   clr        - synchronous stream restart, highest priority
//   tok_valid  - token present
//   tok_ready  - decoder can accept a token (only while idle)
//   tok_data   - token: [13:11] offset, [10:8] length, [7:0] next_char
//   out_valid  - decoded byte valid
//   out_ready  - downstream accepts the byte
//   out_data   - decoded byte
//   byte_count - bytes emitted since reset/clr, wraps
//   err        - sticky illegal-token flag
// ---------------------------------------------------------------------------
module lz77_token_decoder #(
    parameter int HIST_DEPTH = 7,
    parameter int MAX_LEN    = 6,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic [13:0]      tok_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [CNT_W-1:0] byte_count,
    output logic             err
);

    localparam int FILL_W = $clog2(HIST_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        LIT
    } state_t;

    state_t            state_q;
    logic [7:0]        hist [HIST_DEPTH];
    logic [FILL_W-1:0] fill_q;
    logic [2:0]        off_q;
    logic [2:0]        rem_q;
    logic [7:0]        chr_q;

    logic [2:0]        tok_off;
    logic [2:0]        tok_len;
    logic [7:0]        tok_chr;
    logic              tok_illegal;
    logic              fire;

    assign tok_off = tok_data[13:11];
    assign tok_len = tok_data[10:8];
    assign tok_chr = tok_data[7:0];

    // Handshake signals are decoded from the state register alone, so there
    // is never a combinational path from the token side to the output side.
    assign tok_ready = (state_q == IDLE);
    assign out_valid = (state_q != IDLE);
    assign fire      = out_valid && out_ready;

    // A token is illegal if it asks for a copy with no distance, a copy longer
    // than the compressor could ever produce, or reaches further back than the
    // bytes actually emitted so far.
    always_comb begin
        tok_illegal = 1'b0;
        if ((tok_off == 3'd0) && (tok_len != 3'd0)) begin
            tok_illegal = 1'b1;
        end
        if (32'(tok_len) > 32'(MAX_LEN)) begin
            tok_illegal = 1'b1;
        end
        if (32'(tok_off) > 32'(fill_q)) begin
            tok_illegal = 1'b1;
        end
    end

    // Output byte selection. During a copy the source index stays fixed at
    // off-1: the history shifts by one on every emitted byte, so the same
    // index always points the same distance back, which also makes
    // overlapping copies (off < len) replicate correctly.
    always_comb begin
        out_data = 8'd0;
        case (state_q)
            COPY:    out_data = hist[off_q - 3'd1];
            LIT:     out_data = chr_q;
            default: out_data = 8'd0;
        endcase
    end

    // Main sequential block: history window, fill level, byte counter, the
    // sticky error flag and the IDLE/COPY/LIT sequencing. clr behaves exactly
    // like reset but synchronously. Everything except the accept path only
    // moves on an output fire, so backpressure freezes the whole datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fill_q     <= '0;
            off_q      <= 3'd0;
            rem_q      <= 3'd0;
            chr_q      <= 8'd0;
            byte_count <= '0;
            err        <= 1'b0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist[i] <= 8'd0;
            end
        end else if (clr) begin
            state_q    <= IDLE;
            fill_q     <= '0;
            off_q      <= 3'd0;
            rem_q      <= 3'd0;
            chr_q      <= 8'd0;
            byte_count <= '0;
            err        <= 1'b0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist[i] <= 8'd0;
            end
        end else begin
            if (fire) begin
                for (int i = HIST_DEPTH - 1; i > 0; i--) begin
                    hist[i] <= hist[i-1];
                end
                hist[0]    <= out_data;
                byte_count <= byte_count + CNT_W'(1);
                if (32'(fill_q) < 32'(HIST_DEPTH)) begin
                    fill_q <= fill_q + FILL_W'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (tok_valid) begin
                        off_q <= tok_off;
                        chr_q <= tok_chr;
                        if (tok_illegal) begin
                            // Bad tokens still deliver their literal so the
                            // stream keeps its byte alignment.
                            err     <= 1'b1;
                            rem_q   <= 3'd0;
                            state_q <= LIT;
                        end else begin
                            rem_q   <= tok_len;
                            state_q <= (tok_len != 3'd0) ? COPY : LIT;
                        end
                    end
                end
                COPY: begin
                    if (out_ready) begin
                        rem_q <= rem_q - 3'd1;
                        if (rem_q == 3'd1) begin
                            state_q <= LIT;
                        end
                    end
                end
                LIT: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lz77_token_decoder.sv
// ---------------------------------------------------------------------------
// tb_lz77_token_decoder
//
// Scoreboard bench for lz77_token_decoder. The reference model keeps the whole
// decoded stream as a byte queue; a copy of distance d simply re-reads the
// byte d positions from the end of that stream. Expected bytes go into a
// queue when a token is issued, and an independent monitor pops and compares
// on every output fire. Directed scenarios cover latency, overlap, illegal
// tokens, backpressure and reset/clr; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_lz77_token_decoder;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        tok_valid;
    logic        tok_ready;
    logic [13:0] tok_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [15:0] byte_count;
    logic        err;

    int          checks;
    int          failures;

    // Reference model state
    logic [7:0]  m_stream [$];
    logic [7:0]  exp_q [$];
    logic        m_err;
    logic [15:0] m_total;
    logic [15:0] mon_fired;
    logic        rdy_random;

    lz77_token_decoder #(
        .HIST_DEPTH (7),
        .MAX_LEN    (6),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .tok_valid  (tok_valid),
        .tok_ready  (tok_ready),
        .tok_data   (tok_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .byte_count (byte_count),
        .err        (err)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Forget everything the model knows; used alongside rst and clr.
    task automatic clearModel();
        m_stream.delete();
        exp_q.delete();
        m_err     = 1'b0;
        m_total   = 16'd0;
        mon_fired = 16'd0;
    endtask

    // Compute the bytes a token should produce from the stream so far, queue
    // them for the monitor, then hold the token until the DUT accepts it.
    // Returns 1 time unit after the accepting clock edge.
    task automatic applyStimulus(input logic [13:0] tok);
        int         off;
        int         len;
        int         fill;
        bit         accepted;
        logic [7:0] b;
        off  = int'(tok[13:11]);
        len  = int'(tok[10:8]);
        fill = (m_stream.size() > 7) ? 7 : m_stream.size();
        if ((off == 0 && len != 0) || len > 6 || off > fill) begin
            m_err = 1'b1;
            len   = 0;
        end
        for (int k = 0; k < len; k++) begin
            b = m_stream[m_stream.size() - off];
            m_stream.push_back(b);
            exp_q.push_back(b);
        end
        m_stream.push_back(tok[7:0]);
        exp_q.push_back(tok[7:0]);
        m_total = m_total + 16'(len + 1);

        tok_data  = tok;
        tok_valid = 1'b1;
        accepted  = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tok_ready) begin
                @(posedge clk);
                #1;
                accepted = 1'b1;
                break;
            end
        end
        tok_valid = 1'b0;
        if (!accepted) begin
            checkOutput("token_accept_timeout", 32'd0, 32'd1);
        end
    endtask

    // Wait until every expected byte has been seen and the DUT is idle again.
    task automatic waitDrain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && tok_ready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checkOutput("drain_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        clearModel();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares the counter every cycle and pops one expected byte
    // per output fire, independent of what the stimulus side is doing.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("byte_count_track", 32'(byte_count), 32'(mon_fired));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_byte", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
                mon_fired = mon_fired + 16'd1;
            end
        end
    end

    // Random downstream backpressure, active only in the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_random) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        int          low_cycles;
        logic [2:0]  r_off;
        logic [2:0]  r_len;
        logic [7:0]  r_chr;

        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        clr        = 1'b0;
        tok_valid  = 1'b0;
        tok_data   = 14'd0;
        out_ready  = 1'b1;
        rdy_random = 1'b0;
        clearModel();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        checkOutput("reset_tok_ready", 32'(tok_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data", 32'(out_data), 32'd0);
        checkOutput("reset_byte_count", 32'(byte_count), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        rst = 1'b0;

        // Literals then a back-reference, with latency and tok_ready timing
        applyStimulus(14'h0041);
        applyStimulus(14'h0042);
        applyStimulus(14'h0043);
        waitDrain();
        checkOutput("lit_byte_count", 32'(byte_count), 32'd3);
        checkOutput("lit_err", 32'(err), 32'd0);
        applyStimulus(14'h1B44);
        checkOutput("first_byte_latency", 32'(out_valid), 32'd1);
        checkOutput("first_copy_byte", 32'(out_data), 32'h41);
        low_cycles = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tok_ready) break;
            low_cycles++;
        end
        checkOutput("tok_ready_low_cycles", 32'(low_cycles), 32'd4);
        waitDrain();
        checkOutput("copy_byte_count", 32'(byte_count), 32'd7);

        // Overlapping copy
        doReset();
        applyStimulus(14'h0041);
        applyStimulus(14'h0D42);
        waitDrain();
        checkOutput("overlap_byte_count", 32'(byte_count), 32'd7);
        checkOutput("overlap_err", 32'(err), 32'd0);

        // Illegal token: distance beyond the bytes emitted so far
        doReset();
        applyStimulus(14'h115A);
        waitDrain();
        checkOutput("illegal_err", 32'(err), 32'd1);
        checkOutput("illegal_byte_count", 32'(byte_count), 32'd1);
        applyStimulus(14'h0061);
        waitDrain();
        checkOutput("illegal_err_sticky", 32'(err), 32'd1);
        doReset();
        checkOutput("illegal_err_cleared", 32'(err), 32'd0);

        // Backpressure while the second copied byte is presented
        applyStimulus(14'h0041);
        applyStimulus(14'h0042);
        applyStimulus(14'h0043);
        waitDrain();
        applyStimulus(14'h1B44);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_out_data", 32'(out_data), 32'h42);
            checkOutput("stall_byte_count", 32'(byte_count), 32'd4);
        end
        out_ready = 1'b1;
        waitDrain();
        checkOutput("stall_final_count", 32'(byte_count), 32'd7);

        // Reset during the third copied byte
        doReset();
        applyStimulus(14'h0041);
        applyStimulus(14'h0042);
        applyStimulus(14'h0043);
        waitDrain();
        applyStimulus(14'h1B44);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("midcopy_third_byte", 32'(out_data), 32'h43);
        rst = 1'b1;
        clearModel();
        #1;
        checkOutput("midcopy_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midcopy_byte_count", 32'(byte_count), 32'd0);
        checkOutput("midcopy_tok_ready", 32'(tok_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(14'h0055);
        waitDrain();
        checkOutput("after_reset_err", 32'(err), 32'd0);
        checkOutput("after_reset_count", 32'(byte_count), 32'd1);

        // Randomized tokens with random backpressure and occasional clr
        doReset();
        rdy_random = 1'b1;
        for (int n = 0; n < 400; n++) begin
            r_len = 3'($urandom_range(0, 7));
            r_off = 3'($urandom_range(0, 7));
            r_chr = 8'($urandom_range(0, 255));
            if (r_len != 3'd0 && $urandom_range(0, 9) != 0) begin
                r_off = 3'($urandom_range(1, 7));
            end
            applyStimulus({r_off, r_len, r_chr});
            if (n % 97 == 50) begin
                waitDrain();
                checkOutput("rand_err_before_clr", 32'(err), 32'(m_err));
                clr = 1'b1;
                @(posedge clk);
                #1;
                clr = 1'b0;
                clearModel();
                checkOutput("clr_err", 32'(err), 32'd0);
                checkOutput("clr_byte_count", 32'(byte_count), 32'd0);
            end
        end
        waitDrain();
        rdy_random = 1'b0;
        out_ready  = 1'b1;
        checkOutput("rand_err", 32'(err), 32'(m_err));
        checkOutput("rand_byte_count", 32'(byte_count), 32'(m_total));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/lz77_token_decoder.md
Name: lz77_token_decoder

Overview:
- Downstream of the LZ77 compressor; consumes its 14-bit encoded tokens {offset[2:0], length[2:0], next_char[7:0]}.
- Rebuilds the original byte stream using a 7-byte history window that mirrors the compressor's search buffer.
- Emits one byte per cycle on a valid/ready output. Used for on-chip round-trip checking and as the standalone decompressor.

Parameters:
- HIST_DEPTH, 7: history window depth in bytes. Equals the compressor search-buffer depth.
- MAX_LEN, 6: maximum legal match length. Equals the compressor lookahead depth.
- CNT_W, 16: width of the emitted-byte counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous stream restart: clears history, fill, counter and FSM. Priority over all other inputs.
- tok_valid  in  1  token present.
- tok_ready  out  1  decoder can accept a token.
- tok_data  in  14  token: [13:11] offset, [10:8] length, [7:0] next_char.
- out_valid  out  1  output byte valid.
- out_ready  in  1  downstream accepts byte.
- out_data  out  8  decoded byte.
- byte_count  out  CNT_W  total bytes emitted since reset/clr; wraps modulo 2^CNT_W.
- err  out  1  sticky illegal-token flag.

Behaviour:
- Reset (rst=1, async) or clr=1:
  - state=IDLE, tok_ready=1, out_valid=0, out_data=0, byte_count=0, err=0.
  - hist[0..6]=0, fill=0.
- History:
  - hist[0] is the most recent byte.
  - Every output fire (out_valid&out_ready) shifts hist[i+1]<=hist[i] and hist[0]<=out_data.
  - fill increments on each fire, saturating at HIST_DEPTH.
- FSM states: IDLE, COPY, LIT.
- IDLE:
  - tok_ready=1, out_valid=0.
  - On tok_valid: latch off, rem=len and chr.
  - Next state is COPY if the effective length is greater than 0, else LIT.
- Illegal token, checked at accept: (off==0 && len!=0) or len>MAX_LEN or off>fill.
  - Sets err=1; err clears only on rst/clr.
  - The token is treated as literal-only (rem forced 0, goes to LIT).
  - A legal zero-length token may carry any off value; off is ignored.
- COPY:
  - out_valid=1, out_data=hist[off-1]. Combinational from registers only; no path from tok_* to out_*.
  - On fire: rem decrements. If rem was 1, go to LIT.
  - Overlapping copies (off<len) are correct because the history shifts per byte and the source distance stays constant.
- LIT:
  - out_valid=1, out_data=chr.
  - On fire: go to IDLE.
- tok_ready=0 in COPY and LIT.
- Backpressure: while out_valid=1 and out_ready=0, out_data, hist, rem and the state hold stable.
- Latency and throughput:
  - Token accepted at edge N; first byte valid in cycle N+1.
  - A token of length L produces L+1 bytes in L+1 cycles (out_ready=1), followed by 1 IDLE accept cycle.
- byte_count increments on every fire.
- Reset asserted mid-COPY aborts the token immediately; no partial byte is held.

Test Plan:
- Reset, then tokens 14'h0041, 14'h0042, 14'h0043 (literals A, B, C) with out_ready=1 -> out bytes 41, 42, 43; byte_count=3; err=0.
- Continue with token {off=3, len=3, chr=44} = 14'h1B44 -> bytes 41, 42, 43, 44 after the first three. First byte valid 1 cycle after accept; tok_ready low for 4 cycles.
- Overlap: reset, literal 41, then token {off=1, len=5, chr=42} = 14'h0D42 -> 41, 41, 41, 41, 41, 42; byte_count=7.
- Illegal: fresh reset, token {off=2, len=1, chr=5A} = 14'h115A -> err=1, single byte 5A, then IDLE. Err stays 1 until rst.
- Backpressure: during the copy in scenario 2, drop out_ready for 3 cycles after the second byte -> out_data stable at 42, byte_count frozen. Sequence resumes unchanged.
- Reset mid-copy: assert rst during the third COPY byte -> out_valid=0 and byte_count=0 immediately. After release, literal 14'h0055 -> out 55, err=0.
